data_mem_responder: RTL and testbench

//  Data-memory target answering the core's load/store requests over a valid/ready request/response handshake.

---
 rtl/data_mem_responder.sv | 176 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - load/store data memory target with valid/ready handshake and wait states
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_ctrl,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = 16;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            lat_wr;
  logic [31:0]     lat_addr;
  logic [31:0]     lat_wdata;
  logic [2:0]      lat_ctrl;

  logic            accept;
  logic            access_en;
  logic            a_wr;
  logic [31:0]     a_addr;
  logic [31:0]     a_wdata;
  logic [2:0]      a_ctrl;
  logic            ctrl_ok;
  logic            misaligned;
  logic            out_of_range;
  logic            a_err;
  logic [AW-1:0]   idx;
  logic [31:0]     word;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [31:0]     load_v;
  logic [31:0]     rdata_d;
  logic [3:0]      be;
  logic [31:0]     wlanes;

  logic [31:0]     mem [DEPTH_WORDS];

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign accept    = req_valid && req_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: IDLE -> (WAIT ->) RESP -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (cnt_q == '0) state_d = S_RESP;
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Wait-state counter: loaded on accept, counts down while waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;
    end else if (state_q == S_WAIT && cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // Request capture so later input changes cannot disturb the access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_ctrl  <= '0;
    end else if (accept) begin
      lat_wr    <= req_wr;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_ctrl  <= req_ctrl;
    end
  end

  // With zero wait states the access happens on the accept edge itself, so take the live request
  assign a_wr    = (state_q == S_IDLE) ? req_wr    : lat_wr;
  assign a_addr  = (state_q == S_IDLE) ? req_addr  : lat_addr;
  assign a_wdata = (state_q == S_IDLE) ? req_wdata : lat_wdata;
  assign a_ctrl  = (state_q == S_IDLE) ? req_ctrl  : lat_ctrl;

  // The access edge is the one that moves the FSM into RESP; never while reset is held
  assign access_en = rst_n && (state_d == S_RESP) && (state_q != S_RESP);

  // Access legality
  always_comb begin
    ctrl_ok      = a_wr ? (a_ctrl inside {3'b000, 3'b001, 3'b010})
                        : (a_ctrl inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned   = ((a_ctrl[1:0] == 2'b01) && a_addr[0]) ||
                   ((a_ctrl[1:0] == 2'b10) && (a_addr[1:0] != 2'b00));
    out_of_range = ({2'b00, a_addr[31:2]} >= 32'(DEPTH_WORDS));
    a_err        = !ctrl_ok || misaligned || out_of_range;
  end

  assign idx  = a_addr[AW+1:2];
  assign word = mem[idx];

  // Lane selection and sign/zero extension for loads
  always_comb begin
    byte_v = word[8*a_addr[1:0] +: 8];
    half_v = a_addr[1] ? word[31:16] : word[15:0];
    load_v = '0;
    case (a_ctrl)
      3'b000:  load_v = {{24{byte_v[7]}}, byte_v};
      3'b100:  load_v = {24'h0, byte_v};
      3'b001:  load_v = {{16{half_v[15]}}, half_v};
      3'b101:  load_v = {16'h0, half_v};
      3'b010:  load_v = word;
      default: load_v = '0;
    endcase
    rdata_d = (a_wr || a_err) ? 32'h0 : load_v;
  end

  // Store byte enables and lane-replicated write data
  always_comb begin
    be     = 4'b0000;
    wlanes = a_wdata;
    case (a_ctrl[1:0])
      2'b00: begin
        be     = 4'b0001 << a_addr[1:0];
        wlanes = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        be     = a_addr[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{a_wdata[15:0]}};
      end
      2'b10: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Array write commit; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (access_en && a_wr && !a_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  // Response registers, captured on the access edge and held through RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (access_en) begin
      rsp_rdata <= rdata_d;
      rsp_err   <= a_err;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized self-checking bench for data_mem_responder
module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam int WAITC = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_ctrl = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        z_req_valid = 1'b0;
  logic        z_req_ready;
  logic        z_req_wr = 1'b0;
  logic [31:0] z_req_addr = '0;
  logic [31:0] z_req_wdata = '0;
  logic [2:0]  z_req_ctrl = '0;
  logic        z_rsp_valid;
  logic        z_rsp_ready = 1'b0;
  logic [31:0] z_rsp_rdata;
  logic        z_rsp_err;

  logic [7:0]  ref_mem [0:4*DEPTH-1];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ctrl(req_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_wr(z_req_wr),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_ctrl(z_req_ctrl),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Byte-array reference: returns {err, rdata} and applies stores
  function automatic logic [32:0] model(input logic wr, input logic [31:0] addr,
                                        input logic [31:0] wdata, input logic [2:0] ctrl);
    int          size;
    logic        legal;
    logic [31:0] v;
    legal = wr ? (ctrl <= 3'd2) : (ctrl <= 3'd2 || ctrl == 3'd4 || ctrl == 3'd5);
    if (!legal) return {1'b1, 32'h0};
    size = 1 << ctrl[1:0];
    if ((addr % 32'(size)) != 0 || (addr >> 2) >= 32'(DEPTH)) return {1'b1, 32'h0};
    if (wr) begin
      for (int i = 0; i < size; i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
      return {1'b0, 32'h0};
    end
    v = 32'h0;
    for (int i = 0; i < size; i++) v = v | (32'(ref_mem[addr + 32'(i)]) << (8*i));
    if (!ctrl[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
    return {1'b0, v};
  endfunction

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] ctrl, input int hold, input bit early,
                        output logic [31:0] rd, output logic er);
    logic [32:0] exp;
    int          k;
    @(negedge clk);
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata; req_ctrl = ctrl;
    rsp_ready = early;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wr = 1'($urandom_range(0, 1)); req_addr = $urandom; req_wdata = $urandom;
    req_ctrl = 3'($urandom_range(0, 7));
    exp = model(wr, addr, wdata, ctrl);
    k = 1;
    while (!rsp_valid && k < 20) begin @(posedge clk); #1; k++; end
    check("latency", 32'(k), 32'(1 + WAITC));
    rd = rsp_rdata; er = rsp_err;
    check("rdata", rd, exp[31:0]);
    check("err", {31'b0, er}, {31'b0, exp[32]});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'b0, rsp_valid}, 32'd1);
      check("hold_rdata", rsp_rdata, rd);
      check("hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("post_hs_valid", {31'b0, rsp_valid}, 32'd0);
  endtask

  task automatic z_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] ctrl, output logic [31:0] rd, output logic er,
                       output int k);
    @(negedge clk);
    z_req_valid = 1'b1; z_req_wr = wr; z_req_addr = addr; z_req_wdata = wdata; z_req_ctrl = ctrl;
    @(posedge clk); #1;
    z_req_valid = 1'b0; z_req_addr = $urandom; z_req_wdata = $urandom;
    k = 1;
    while (!z_rsp_valid && k < 20) begin @(posedge clk); #1; k++; end
    rd = z_rsp_rdata; er = z_rsp_err;
    z_rsp_ready = 1'b1;
    @(posedge clk); #1;
    z_rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, old20, ra;
    logic        er;
    logic [32:0] e1, e2;
    logic [2:0]  c;
    logic        w;
    int          k;
    int          hold;
    bit          early;
    logic [2:0]  legal_ctrl [5];
    legal_ctrl[0] = 3'd0; legal_ctrl[1] = 3'd1; legal_ctrl[2] = 3'd2;
    legal_ctrl[3] = 3'd4; legal_ctrl[4] = 3'd5;

    #2;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err", {31'b0, rsp_err}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 64; i++)
      do_req(1'b1, 32'(4*i), $urandom, 3'd2, 0, bit'($urandom_range(0, 1)), rd, er);

    do_req(1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 0, 1'b0, rd, er);
    do_req(1'b0, 32'h10, 32'h0, 3'd2, 0, 1'b0, rd, er);
    check("t1_lw", rd, 32'hDEADBEEF);
    do_req(1'b1, 32'h11, 32'h0000007F, 3'd0, 0, 1'b0, rd, er);
    do_req(1'b0, 32'h10, 32'h0, 3'd2, 0, 1'b0, rd, er);
    check("t2_lw", rd, 32'hDEAD7FEF);
    do_req(1'b0, 32'h13, 32'h0, 3'd0, 0, 1'b0, rd, er);
    check("t2_lb", rd, 32'hFFFFFFDE);
    do_req(1'b0, 32'h13, 32'h0, 3'd4, 0, 1'b0, rd, er);
    check("t2_lbu", rd, 32'h000000DE);
    do_req(1'b0, 32'h12, 32'h0, 3'd1, 0, 1'b0, rd, er);
    check("t2_lh", rd, 32'hFFFFDEAD);
    do_req(1'b0, 32'h12, 32'h0, 3'd2, 0, 1'b0, rd, er);
    check("t3_lw_mis", {er, rd[30:0]}, 32'h80000000);
    do_req(1'b1, 32'h11, 32'h0000AAAA, 3'd1, 0, 1'b0, rd, er);
    check("t3_sh_mis", {31'b0, er}, 32'd1);
    do_req(1'b0, 32'h10, 32'h0, 3'd2, 0, 1'b0, rd, er);
    check("t3_unchanged", rd, 32'hDEAD7FEF);
    do_req(1'b0, 32'h1000, 32'h0, 3'd2, 0, 1'b0, rd, er);
    check("t4_range", {31'b0, er}, 32'd1);
    do_req(1'b0, 32'h10, 32'h0, 3'd3, 0, 1'b0, rd, er);
    check("t4_illegal", {31'b0, er}, 32'd1);

    for (int i = 0; i < 250; i++) begin
      w = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7))
                                      : legal_ctrl[$urandom_range(w ? 2 : 4, 0)];
      if ($urandom_range(0, 9) == 0)
        ra = ($urandom_range(0, 1) == 1) ? (32'h1000 + 32'($urandom_range(0, 255))) : $urandom;
      else
        ra = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) ra = ra & ~((32'd1 << c[1:0]) - 32'd1);
      early = ($urandom_range(0, 3) == 0);
      hold = early ? 0 : $urandom_range(0, 3);
      do_req(w, ra, $urandom, c, hold, early, rd, er);
    end

    e1 = model(1'b0, 32'h10, 32'h0, 3'd2);
    e2 = model(1'b0, 32'h14, 32'h0, 3'd2);
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h10; req_ctrl = 3'd2;
    @(posedge clk); #1;
    req_addr = 32'h14;
    k = 1;
    while (!rsp_valid && k < 20) begin @(posedge clk); #1; k++; end
    check("t5_rdata1", rsp_rdata, e1[31:0]);
    rd = rsp_rdata;
    for (int h = 0; h < 5; h++) begin
      @(posedge clk); #1;
      check("t5_valid", {31'b0, rsp_valid}, 32'd1);
      check("t5_stable", rsp_rdata, rd);
      check("t5_req_ready", {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("t5_idle_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 1;
    while (!rsp_valid && k < 20) begin @(posedge clk); #1; k++; end
    check("t5_latency2", 32'(k), 32'(1 + WAITC));
    check("t5_rdata2", rsp_rdata, e2[31:0]);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    old20 = model(1'b0, 32'h20, 32'h0, 3'd2);
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_ctrl = 3'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("t6_req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    do_req(1'b0, 32'h20, 32'h0, 3'd2, 0, 1'b0, rd, er);
    check("t6_old", rd, old20);

    z_req(1'b1, 32'h8, 32'hA5A55A5A, 3'd2, rd, er, k);
    check("z_sw_latency", 32'(k), 32'd1);
    z_req(1'b0, 32'h8, 32'h0, 3'd2, rd, er, k);
    check("z_lw_latency", 32'(k), 32'd1);
    check("z_lw", rd, 32'hA5A55A5A);
    z_req(1'b0, 32'hA, 32'h0, 3'd5, rd, er, k);
    check("z_lhu", rd, 32'h0000A5A5);
    z_req(1'b0, 32'h8, 32'h0, 3'd0, rd, er, k);
    check("z_lb", rd, 32'h0000005A);
    z_req(1'b0, 32'h9, 32'h0, 3'd2, rd, er, k);
    check("z_mis", {31'b0, er}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
